// File: rtl/calc_pkg.sv
// Shared constants and FSM encoding for the calculator result printer.
// Holds operator codes, ASCII bytes and the printer state enum.
package calc_pkg;

  localparam logic [2:0] OPC_SUB = 3'b001;

  localparam logic [7:0] CH_ZERO  = 8'h30;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_CONV  = 3'd2,
    ST_SIGN  = 3'd3,
    ST_DIGIT = 3'd4,
    ST_EOL   = 3'd5
  } state_e;

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble binary to BCD converter, one bit per clock.
// bcd holds its value after done until the next start.
module calc_bin2bcd #(
  parameter int RESW = 8,
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RESW-1:0]   bin,
  output logic              done,
  output logic [4*NDIG-1:0] bcd
);

  localparam int CW = $clog2(RESW + 1);

  logic [RESW-1:0]   sh_q, sh_d;
  logic [4*NDIG-1:0] bcd_q, bcd_d, adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              done_q, done_d;

  // add-3 correction applied before each shift
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDIG; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (start) begin
      sh_d  = bin;
      bcd_d = '0;
      cnt_d = CW'(RESW);
    end else if (cnt_q != '0) begin
      bcd_d  = {adj[4*NDIG-2:0], sh_q[RESW-1]};
      sh_d   = {sh_q[RESW-2:0], 1'b0};
      cnt_d  = cnt_q - 1'b1;
      done_d = (cnt_q == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/calc_result_printer.sv
// Calculator front end: registers operands, prints the result as ASCII.
// Define CALC_PRINT_CRLF_EN to terminate lines with CR LF instead of LF.
module calc_result_printer
  import calc_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int OPCW = 3,
  parameter int RESW = 8,
  parameter int NDIG = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [OPW-1:0]  req_a,
  input  logic [OPW-1:0]  req_b,
  input  logic [OPCW-1:0] req_optr,
  output logic [OPW-1:0]  calc_a,
  output logic [OPW-1:0]  calc_b,
  output logic [OPCW-1:0] calc_optr,
  input  logic [RESW-1:0] calc_result,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic [7:0]      tx_data,
  output logic            busy
);

`ifdef CALC_PRINT_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e            state_q, state_d;
  logic [OPW-1:0]    calc_a_q, calc_a_d;
  logic [OPW-1:0]    calc_b_q, calc_b_d;
  logic [OPCW-1:0]   calc_optr_q, calc_optr_d;
  logic              neg_q, neg_d;
  logic [DW-1:0]     dig_q, dig_d;
  logic              lf_q, lf_d;

  logic              conv_start;
  logic              conv_done;
  logic [4*NDIG-1:0] bcd;
  logic [DW-1:0]     first_idx;
  logic [3:0]        cur_digit;

  assign conv_start = (state_q == ST_EXEC);

  calc_bin2bcd #(
    .RESW (RESW),
    .NDIG (NDIG)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .bin   (calc_result),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // highest nonzero digit; zero value falls back to digit 0
  always_comb begin
    first_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        first_idx = DW'(i);
      end
    end
  end

  assign cur_digit = bcd[4*dig_q +: 4];

  always_comb begin
    state_d     = state_q;
    calc_a_d    = calc_a_q;
    calc_b_d    = calc_b_q;
    calc_optr_d = calc_optr_q;
    neg_d       = neg_q;
    dig_d       = dig_q;
    lf_d        = lf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          calc_a_d    = req_a;
          calc_b_d    = req_b;
          calc_optr_d = req_optr;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        neg_d   = (calc_optr_q == OPCW'(OPC_SUB))
                  && (calc_a_q < calc_b_q);
        state_d = ST_CONV;
      end
      ST_CONV: begin
        if (conv_done) begin
          dig_d   = first_idx;
          state_d = neg_q ? ST_SIGN : ST_DIGIT;
        end
      end
      ST_SIGN: begin
        if (tx_ready) state_d = ST_DIGIT;
      end
      ST_DIGIT: begin
        if (tx_ready) begin
          if (dig_q == '0) begin
            lf_d    = !CRLF;
            state_d = ST_EOL;
          end else begin
            dig_d = dig_q - 1'b1;
          end
        end
      end
      ST_EOL: begin
        if (tx_ready) begin
          if (lf_q) state_d = ST_IDLE;
          else      lf_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      calc_a_q    <= '0;
      calc_b_q    <= '0;
      calc_optr_q <= '0;
      neg_q       <= 1'b0;
      dig_q       <= '0;
      lf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      calc_a_q    <= calc_a_d;
      calc_b_q    <= calc_b_d;
      calc_optr_q <= calc_optr_d;
      neg_q       <= neg_d;
      dig_q       <= dig_d;
      lf_q        <= lf_d;
    end
  end

  always_comb begin
    tx_data = 8'h00;
    unique case (state_q)
      ST_SIGN:  tx_data = CH_MINUS;
      ST_DIGIT: tx_data = CH_ZERO + {4'd0, cur_digit};
      ST_EOL:   tx_data = (CRLF && !lf_q) ? CH_CR : CH_LF;
      default:  tx_data = 8'h00;
    endcase
  end

  assign tx_valid  = (state_q == ST_SIGN) || (state_q == ST_DIGIT)
                     || (state_q == ST_EOL);
  assign busy      = (state_q != ST_IDLE);
  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign calc_a    = calc_a_q;
  assign calc_b    = calc_b_q;
  assign calc_optr = calc_optr_q;

endmodule

// File: tb/tb_calc_result_printer.sv
// Directed bench for calc_result_printer with a stubbed calculator.
// Define CALC_PRINT_CRLF_EN to expect CR LF line endings.
module tb_calc_result_printer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a, req_b;
  logic [2:0] req_optr;
  logic [3:0] calc_a, calc_b;
  logic [2:0] calc_optr;
  logic [7:0] calc_result;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] got [8];
  int         got_n;
  logic [7:0] exp_b [8];
  int         exp_n;

  always #5 clk = ~clk;

  calc_result_printer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_optr    (req_optr),
    .calc_a      (calc_a),
    .calc_b      (calc_b),
    .calc_optr   (calc_optr),
    .calc_result (calc_result),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .busy        (busy)
  );

  // expected text: nb leading bytes of v (MSB first) plus line end
  task automatic set_exp(input logic [31:0] v, input int nb);
    exp_n = 0;
    for (int i = 0; i < nb; i++) begin
      exp_b[exp_n] = v[31-8*i -: 8];
      exp_n++;
    end
`ifdef CALC_PRINT_CRLF_EN
    exp_b[exp_n] = 8'h0D;
    exp_n++;
`endif
    exp_b[exp_n] = 8'h0A;
    exp_n++;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op, input logic [7:0] res,
                       output int lat);
    @(negedge clk);
    req_a       = a;
    req_b       = b;
    req_optr    = op;
    calc_result = res;
    req_valid   = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!tx_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic collect();
    got_n = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (tx_valid) begin
        got[got_n] = tx_data;
        got_n++;
        if (tx_data == 8'h0A || got_n == 8) break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL reset_out: valid=%b busy=%b data=%h required 0 0 00",
               tx_valid, busy, tx_data);
    else n_pass++;
    n_checks++;
    if ({calc_a, calc_b, calc_optr} !== 11'd0)
      $display("FAIL reset_calc: got %h required 000",
               {calc_a, calc_b, calc_optr});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 1'b1 || tx_valid !== 1'b0)
      $display("FAIL reset_release: ready=%b valid=%b required 1 0",
               req_ready, tx_valid);
    else n_pass++;
  endtask

  task automatic test_neg_sub();
    int lat;
    issue(4'd3, 4'd5, 3'b001, 8'd2, lat);
    n_checks++;
    if (lat !== 10) $display("FAIL neg_latency: got %0d required 10", lat);
    else n_pass++;
    n_checks++;
    if (calc_a !== 4'd3 || calc_b !== 4'd5 || calc_optr !== 3'b001)
      $display("FAIL neg_calc_regs: got %h %h %h required 3 5 1",
               calc_a, calc_b, calc_optr);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL neg_busy: got %b required 1", busy);
    else n_pass++;
    collect();
    set_exp(32'h2D32_0000, 2);
    n_checks++;
    if (got_n !== exp_n)
      $display("FAIL neg_len: got %0d required %0d", got_n, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n; i++) begin
      n_checks++;
      if (got[i] !== exp_b[i])
        $display("FAIL neg_byte%0d: got %h required %h", i, got[i], exp_b[i]);
      else n_pass++;
    end
    n_checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL neg_idle: busy=%b ready=%b required 0 1",
               busy, req_ready);
    else n_pass++;
  endtask

  task automatic test_pos_ops();
    logic [3:0]  ta [2] = '{4'd5, 4'd8};
    logic [3:0]  tb_ [2] = '{4'd3, 4'd10};
    logic [2:0]  top [2] = '{3'b001, 3'b111};
    logic [7:0]  tr [2] = '{8'd2, 8'd80};
    logic [31:0] te [2] = '{32'h3200_0000, 32'h3830_0000};
    int          tn [2] = '{1, 2};
    int lat;
    for (int t = 0; t < 2; t++) begin
      issue(ta[t], tb_[t], top[t], tr[t], lat);
      n_checks++;
      if (lat !== 10)
        $display("FAIL pos%0d_latency: got %0d required 10", t, lat);
      else n_pass++;
      collect();
      set_exp(te[t], tn[t]);
      n_checks++;
      if (got_n !== exp_n)
        $display("FAIL pos%0d_len: got %0d required %0d", t, got_n, exp_n);
      else n_pass++;
      for (int i = 0; i < exp_n; i++) begin
        n_checks++;
        if (got[i] !== exp_b[i])
          $display("FAIL pos%0d_byte%0d: got %h required %h",
                   t, i, got[i], exp_b[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_digit_bounds();
    logic [7:0]  tr [3] = '{8'd0, 8'd255, 8'd100};
    logic [31:0] te [3] = '{32'h3000_0000, 32'h3235_3500, 32'h3130_3000};
    int          tn [3] = '{1, 3, 3};
    int lat;
    for (int t = 0; t < 3; t++) begin
      issue(4'd0, 4'd0, 3'b010, tr[t], lat);
      collect();
      set_exp(te[t], tn[t]);
      n_checks++;
      if (got_n !== exp_n)
        $display("FAIL bound%0d_len: got %0d required %0d", t, got_n, exp_n);
      else n_pass++;
      for (int i = 0; i < exp_n; i++) begin
        n_checks++;
        if (got[i] !== exp_b[i])
          $display("FAIL bound%0d_byte%0d: got %h required %h",
                   t, i, got[i], exp_b[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int bad;
    issue(4'd0, 4'd0, 3'b011, 8'd255, lat);
    @(negedge clk);
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h32)
      $display("FAIL bp_first: valid=%b data=%h required 1 32",
               tx_valid, tx_data);
    else n_pass++;
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h35) bad++;
      if (k == 1) begin
        req_a     = 4'd7;
        req_valid = 1'b1;
        n_checks++;
        if (req_ready !== 1'b0)
          $display("FAIL bp_req_ready: got %b required 0", req_ready);
        else n_pass++;
      end
      if (k == 2) req_valid = 1'b0;
    end
    n_checks++;
    if (bad !== 0)
      $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
    else n_pass++;
    tx_ready = 1'b1;
    collect();
    set_exp(32'h3500_0000, 1);
    n_checks++;
    if (got_n !== exp_n)
      $display("FAIL bp_len: got %0d required %0d", got_n, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n; i++) begin
      n_checks++;
      if (got[i] !== exp_b[i])
        $display("FAIL bp_byte%0d: got %h required %h", i, got[i], exp_b[i]);
      else n_pass++;
    end
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy !== 1'b0 || calc_a !== 4'd0) bad++;
    end
    n_checks++;
    if (bad !== 0)
      $display("FAIL bp_no_accept: %0d busy cycles required 0", bad);
    else n_pass++;
  endtask

  task automatic test_reset_midstream();
    int lat;
    int bad;
    issue(4'd3, 4'd4, 3'b111, 8'd100, lat);
    @(negedge clk);
    n_checks++;
    if (tx_data !== 8'h31)
      $display("FAIL mid_first: got %h required 31", tx_data);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00)
      $display("FAIL mid_rst_out: valid=%b busy=%b data=%h required 0 0 00",
               tx_valid, busy, tx_data);
    else n_pass++;
    n_checks++;
    if ({calc_a, calc_b, calc_optr} !== 11'd0)
      $display("FAIL mid_rst_calc: got %h required 000",
               {calc_a, calc_b, calc_optr});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0)
      $display("FAIL mid_silent: %0d valid cycles required 0", bad);
    else n_pass++;
    issue(4'd1, 4'd1, 3'b000, 8'd2, lat);
    n_checks++;
    if (lat !== 10) $display("FAIL mid_latency: got %0d required 10", lat);
    else n_pass++;
    collect();
    set_exp(32'h3200_0000, 1);
    n_checks++;
    if (got_n !== exp_n)
      $display("FAIL mid_len: got %0d required %0d", got_n, exp_n);
    else n_pass++;
    for (int i = 0; i < exp_n; i++) begin
      n_checks++;
      if (got[i] !== exp_b[i])
        $display("FAIL mid_byte%0d: got %h required %h", i, got[i], exp_b[i]);
      else n_pass++;
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_a       = 4'd0;
    req_b       = 4'd0;
    req_optr    = 3'd0;
    calc_result = 8'd0;
    tx_ready    = 1'b1;
    test_reset();
    test_neg_sub();
    test_pos_ops();
    test_digit_bounds();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
